// File: rtl/rv_inv_revaluate_unit.sv
// Inverse Revaluate (chi) stage: decodes one 25-bit slice, one 5-bit row per cycle.
// Optional build macro RV_INV_CHECK_EN adds chk_err, a forward-chi self-check of the result.
module rv_inv_revaluate_unit #(
  parameter int ROW_W    = 5,
  parameter int NUM_ROWS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROW_W*NUM_ROWS-1:0] data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROW_W*NUM_ROWS-1:0] new_data,
  output logic                      busy
`ifdef RV_INV_CHECK_EN
  ,
  output logic                      chk_err
`endif
);
  localparam int SW = ROW_W * NUM_ROWS;

  typedef enum logic [1:0] {IDLE, ROW, DONE} state_t;

  state_t          state;
  logic [2:0]      row;
  logic [SW-1:0]   in_reg;
  logic [SW-1:0]   work;
  logic [SW-1:0]   next_work;

  function automatic logic [4:0] chi5(input logic [4:0] a);
    logic [4:0] r;
    r[0] = a[0] ^ (~a[1] & a[2]);
    r[1] = a[1] ^ (~a[2] & a[3]);
    r[2] = a[2] ^ (~a[3] & a[4]);
    r[3] = a[3] ^ (~a[4] & a[0]);
    r[4] = a[4] ^ (~a[0] & a[1]);
    return r;
  endfunction

  // chi5 is a bijection, so exactly one candidate matches; synthesis folds this to a table.
  function automatic logic [4:0] inv5(input logic [4:0] b);
    logic [4:0] r;
    r = '0;
    for (int c = 0; c < 32; c++)
      if (chi5(5'(c)) == b) r = 5'(c);
    return r;
  endfunction

  always_comb begin
    next_work = work;
    next_work[ROW_W*row +: ROW_W] = inv5(in_reg[ROW_W*row +: ROW_W]);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      in_reg    <= '0;
      work      <= '0;
      new_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_reg <= data;
          work   <= '0;
          row    <= '0;
          state  <= ROW;
        end
        ROW: begin
          work <= next_work;
          // last row lands directly in new_data so out_valid rises with it
          if (row == 3'(NUM_ROWS - 1)) begin
            row       <= '0;
            new_data  <= next_work;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            row <= row + 3'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RV_INV_CHECK_EN
  function automatic logic [SW-1:0] chi_slice(input logic [SW-1:0] a);
    logic [SW-1:0] r;
    r = '0;
    for (int y = 0; y < NUM_ROWS; y++)
      r[ROW_W*y +: ROW_W] = chi5(a[ROW_W*y +: ROW_W]);
    return r;
  endfunction

  assign chk_err = out_valid && (chi_slice(work) != in_reg);
`endif

endmodule
